// File: rtl/ascii_number_parser_pkg.sv
// Shared constants and types for the ASCII decimal number parser.
// Holds character codes, FSM states, byte classes and a power-of-ten helper.
package ascii_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DISCARD,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        CLS_DIGIT,
        CLS_TERM,
        CLS_OTHER
    } cls_e;

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/ascii_number_parser_classifier.sv
// Combinational byte classifier: digit, line terminator or other.
// Also yields the 4-bit value of a digit (zero for non-digits).
module ascii_char_classifier
    import ascii_pkg::*;
(
    input  logic [7:0] data_i,
    output cls_e       cls_o,
    output logic [3:0] digit_o
);

    logic is_digit;
    logic is_term;

    assign is_digit = (data_i >= ASCII_ZERO) && (data_i <= ASCII_NINE);
    assign is_term  = (data_i == ASCII_CR) || (data_i == ASCII_LF);

    // Priority-free class decode; the two ranges never overlap.
    always_comb begin
        cls_o   = CLS_OTHER;
        digit_o = 4'd0;
        unique case (1'b1)
            is_digit: begin
                cls_o   = CLS_DIGIT;
                digit_o = data_i[3:0];
            end
            is_term: begin
                cls_o = CLS_TERM;
            end
            default: begin
                cls_o = CLS_OTHER;
            end
        endcase
    end

endmodule

// File: rtl/ascii_number_parser.sv
// ASCII decimal byte stream to unsigned binary, one number per CR/LF line.
// Running multiply-by-10 accumulate; malformed or too-long lines flag error.
module ascii_number_parser
    import ascii_pkg::*;
#(
    parameter int MAX_DIGITS = 6,
    parameter int W          = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_value,
    output logic         out_error,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    generate
        if (pow10(MAX_DIGITS) - 64'd1 >= (64'd1 << W)) begin : g_bad_width
            $error("W too narrow for MAX_DIGITS decimal digits");
        end
    endgenerate

    state_e          state_q, state_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [W-1:0]    val_q, val_d;
    logic            err_q, err_d;
    logic            vld_q, vld_d;

    cls_e            cls;
    logic [3:0]      digit;
    logic            in_fire;
    logic            out_fire;
    logic [W+3:0]    acc_x;
    logic [W+3:0]    acc_next;
    logic            unused_hi;

    ascii_char_classifier u_cls (
        .data_i  (in_data),
        .cls_o   (cls),
        .digit_o (digit)
    );

    assign in_ready  = (state_q != DONE);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = vld_q && out_ready;
    assign out_value = val_q;
    assign out_error = err_q;
    assign out_valid = vld_q;

    // acc*10 + d computed as shifts and adds at W+4 bits.
    assign acc_x     = {4'b0, acc_q};
    assign acc_next  = (acc_x << 3) + (acc_x << 1) + {{W{1'b0}}, digit};
    assign unused_hi = ^acc_next[W+3:W];

    // Next-state and datapath decisions per state and byte class.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        val_d   = val_q;
        err_d   = err_q;
        vld_d   = vld_q;
        unique case (state_q)
            IDLE: begin
                if (in_fire) begin
                    unique case (cls)
                        CLS_DIGIT: begin
                            acc_d   = {{(W-4){1'b0}}, digit};
                            count_d = CW'(1);
                            state_d = ACCUM;
                        end
                        CLS_TERM: begin
                            state_d = IDLE;
                        end
                        default: begin
                            state_d = DISCARD;
                        end
                    endcase
                end
            end
            ACCUM: begin
                if (in_fire) begin
                    unique case (cls)
                        CLS_DIGIT: begin
                            if (count_q == CW'(MAX_DIGITS)) begin
                                state_d = DISCARD;
                            end else begin
                                acc_d   = acc_next[W-1:0];
                                count_d = count_q + CW'(1);
                            end
                        end
                        CLS_TERM: begin
                            val_d   = acc_q;
                            err_d   = 1'b0;
                            vld_d   = 1'b1;
                            state_d = DONE;
                        end
                        default: begin
                            state_d = DISCARD;
                        end
                    endcase
                end
            end
            DISCARD: begin
                if (in_fire && (cls == CLS_TERM)) begin
                    val_d   = '0;
                    err_d   = 1'b1;
                    vld_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_fire) begin
                    vld_d   = 1'b0;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            val_q   <= '0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            val_q   <= val_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
        end
    end

endmodule

// File: tb/tb_ascii_number_parser.sv
// Directed bench for ascii_number_parser: vector table plus corner sequences.
// Results are captured by a handshake monitor and compared to fixed values.
module tb_ascii_number_parser;

    localparam int W = 20;

    logic         clk;
    logic         rst_n;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_value;
    logic         out_error;
    logic         out_valid;
    logic         out_ready;

    int n_checks;
    int n_fail;
    int last_stall;

    logic [W:0] res_q[$];

    typedef struct {
        logic [95:0]  txt;
        int           n;
        logic [W-1:0] val;
        logic         err;
    } vec_t;

    vec_t vecs[9];

    ascii_number_parser #(
        .MAX_DIGITS (6),
        .W          (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_value (out_value),
        .out_error (out_error),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            res_q.push_back({out_error, out_value});
        end
    end

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done;
        done = 1'b0;
        last_stall = 0;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (in_ready) done = 1'b1;
            else last_stall++;
            tick();
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: byte 0x%0h never accepted", b);
        end
    endtask

    task automatic send_str(input logic [95:0] txt, input int n);
        for (int i = 0; i < n; i++) begin
            send_byte(txt[8*(n-1-i) +: 8]);
        end
    endtask

    task automatic expect_one(input string name, input logic [W-1:0] v,
                              input logic e);
        logic [W:0] r;
        for (int i = 0; i < 4; i++) tick();
        check({name, "_count"}, res_q.size(), 1);
        if (res_q.size() > 0) begin
            r = res_q.pop_front();
            check({name, "_value"}, r[W-1:0], v);
            check({name, "_error"}, r[W], e);
        end
        res_q.delete();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        vecs[0] = '{txt: "123456\r",   n: 7, val: 20'h1E240, err: 1'b0};
        vecs[1] = '{txt: "999999\n",   n: 7, val: 20'hF423F, err: 1'b0};
        vecs[2] = '{txt: "0\r",        n: 2, val: 20'h00000, err: 1'b0};
        vecs[3] = '{txt: "\r\n42\r\n\r", n: 7, val: 20'h0002A, err: 1'b0};
        vecs[4] = '{txt: "7\r",        n: 2, val: 20'h00007, err: 1'b0};
        vecs[5] = '{txt: "1234567\r",  n: 8, val: 20'h00000, err: 1'b1};
        vecs[6] = '{txt: "000001\r",   n: 7, val: 20'h00001, err: 1'b0};
        vecs[7] = '{txt: " 3\r",       n: 3, val: 20'h00000, err: 1'b1};
        vecs[8] = '{txt: "100000\r",   n: 7, val: 20'h186A0, err: 1'b0};

        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_value", out_value, 0);
        check("rst_out_error", out_error, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Latency: result visible right after the CR edge, for one cycle.
        send_str("123456", 6);
        send_byte(8'h0D);
        check("lat_valid_now", out_valid, 1);
        check("lat_value_now", out_value, 20'h1E240);
        tick();
        check("lat_valid_gone", out_valid, 0);
        check("lat_ready_back", in_ready, 1);
        for (int i = 0; i < 3; i++) tick();
        check("lat_count", res_q.size(), 1);
        res_q.delete();

        for (int k = 0; k < 9; k++) begin
            send_str(vecs[k].txt, vecs[k].n);
            expect_one($sformatf("vec%0d", k), vecs[k].val, vecs[k].err);
        end

        // Bytes after a bad character are still accepted without stall.
        send_str("12a", 3);
        send_byte("4");
        check("bad_4_stall", last_stall, 0);
        send_byte(8'h0D);
        check("bad_cr_stall", last_stall, 0);
        expect_one("bad", 20'h0, 1'b1);

        // Consumer back-pressure holds the result and blocks input.
        out_ready = 1'b0;
        send_str("55\r", 3);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold%0d_valid", i), out_valid, 1);
            check($sformatf("hold%0d_value", i), out_value, 55);
            check($sformatf("hold%0d_ready", i), in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        expect_one("hold", 20'd55, 1'b0);

        // Asynchronous reset in the middle of a number.
        send_str("12", 2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        #2 rst_n = 1'b1;
        tick();
        check("post_rst_count", res_q.size(), 0);
        send_str("8\r", 2);
        expect_one("post_rst", 20'd8, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
